// File: rtl/tmr_input_conditioner.sv
// -----------------------------------------------------------------------------
// tmr_input_conditioner
//
// Front end for a 3-input majority voter. Each of three redundant raw lanes
// goes through its own synchroniser and debouncer. The stable results are
// presented as a/b/c. An agreement monitor watches the debounced lanes. It
// raises a sticky mismatch fault when a single lane is the odd one out for
// MISMATCH_LIMIT consecutive cycles. The monitor only reports; it never alters
// a/b/c.
//
// Parameters
//   SYNC_STAGES      flops per lane synchroniser (>= 2)
//   DEBOUNCE_CYCLES  cycles a synchronised change must persist (>= 1)
//   MISMATCH_LIMIT   consecutive same-lane disagreement cycles to fault (>= 1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   raw_a/b/c    raw lane inputs, asynchronous to clk
//   clear_fault  one-cycle pulse, clears a latched fault
//   a/b/c        debounced lanes
//   agree        combinational a==b==c
//   mismatch     sticky fault flag
//   fault_lane   lane latched at fault: 0 none, 1 A, 2 B, 3 C
//   fault_count  saturating count of fault entries (only with the macro below)
//
// Build option: define TMR_FAULT_COUNT_EN to add the fault_count port/counter.
// -----------------------------------------------------------------------------
module tmr_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MISMATCH_LIMIT  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_a,
    input  logic       raw_b,
    input  logic       raw_c,
    input  logic       clear_fault,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       agree,
    output logic       mismatch,
`ifdef TMR_FAULT_COUNT_EN
    output logic [1:0] fault_lane,
    output logic [7:0] fault_count
`else
    output logic [1:0] fault_lane
`endif
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W = $clog2(MISMATCH_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_AGREE    = 2'd0,
        ST_DISAGREE = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    logic [2:0] raw_vec;
    logic [2:0] lane_out;

    assign raw_vec = {raw_c, raw_b, raw_a};

    // ---------------- per-lane synchroniser + debouncer ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
            logic                   out_q, out_d;
            logic                   s;

            assign s = sync_q[SYNC_STAGES-1];

            always_comb begin
                sync_d   = {sync_q[SYNC_STAGES-2:0], raw_vec[gi]};
                out_d    = out_q;
                db_cnt_d = db_cnt_q;
                if (s == out_q) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    // This edge is the DEBOUNCE_CYCLES-th consecutive one with s != out.
                    out_d    = s;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q   <= '0;
                    db_cnt_q <= '0;
                    out_q    <= 1'b0;
                end else begin
                    sync_q   <= sync_d;
                    db_cnt_q <= db_cnt_d;
                    out_q    <= out_d;
                end
            end

            assign lane_out[gi] = out_q;
        end
    endgenerate

    assign a     = lane_out[0];
    assign b     = lane_out[1];
    assign c     = lane_out[2];
    assign agree = (lane_out[0] == lane_out[1]) && (lane_out[1] == lane_out[2]);

    // With three binary lanes, any disagreement has exactly one odd lane out.
    logic [1:0] minority;
    always_comb begin
        minority = 2'd0;
        if (!agree) begin
            if (lane_out[0] == lane_out[1])      minority = 2'd3;
            else if (lane_out[0] == lane_out[2]) minority = 2'd2;
            else                                 minority = 2'd1;
        end
    end

    // ---------------- agreement monitor ----------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cur_lane_q, cur_lane_d;
    logic             mismatch_q, mismatch_d;
    logic [1:0]       fault_lane_q, fault_lane_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_lane_d   = cur_lane_q;
        mismatch_d   = mismatch_q;
        fault_lane_d = fault_lane_q;
        case (state_q)
            ST_AGREE: begin
                if (!agree) begin
                    cur_lane_d = minority;
                    cnt_d      = CNT_W'(1);
                    if (MISMATCH_LIMIT == 1) begin
                        // The first disagreeing edge already meets the limit.
                        state_d      = ST_FAULT;
                        mismatch_d   = 1'b1;
                        fault_lane_d = minority;
                    end else begin
                        state_d = ST_DISAGREE;
                    end
                end
            end
            ST_DISAGREE: begin
                if (agree) begin
                    state_d = ST_AGREE;
                    cnt_d   = '0;
                end else if (minority != cur_lane_q) begin
                    // A different lane is now the odd one: restart the run.
                    cur_lane_d = minority;
                    cnt_d      = CNT_W'(1);
                end else begin
                    // Leaving for FAULT at LIMIT-1 keeps cnt from passing LIMIT.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MISMATCH_LIMIT - 1)) begin
                        state_d      = ST_FAULT;
                        mismatch_d   = 1'b1;
                        fault_lane_d = cur_lane_q;
                    end
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_d      = ST_AGREE;
                    mismatch_d   = 1'b0;
                    fault_lane_d = 2'd0;
                    cnt_d        = '0;
                end
            end
            default: begin
                state_d = ST_AGREE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_AGREE;
            cnt_q        <= '0;
            cur_lane_q   <= 2'd0;
            mismatch_q   <= 1'b0;
            fault_lane_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_lane_q   <= cur_lane_d;
            mismatch_q   <= mismatch_d;
            fault_lane_q <= fault_lane_d;
        end
    end

    assign mismatch   = mismatch_q;
    assign fault_lane = fault_lane_q;

`ifdef TMR_FAULT_COUNT_EN
    // Counts every entry into FAULT; clear_fault leaves it alone.
    logic [7:0] fault_count_q, fault_count_d;
    logic       enter_fault;

    assign enter_fault = (state_d == ST_FAULT) && (state_q != ST_FAULT);

    always_comb begin
        fault_count_d = fault_count_q;
        if (enter_fault && (fault_count_q != 8'hFF)) begin
            fault_count_d = fault_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count_q <= 8'd0;
        end else begin
            fault_count_q <= fault_count_d;
        end
    end

    assign fault_count = fault_count_q;
`endif

endmodule

// File: tb/tb_tmr_input_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for tmr_input_conditioner (default parameters).
// Phase 1 applies a hand-derived vector table of multi-cycle sequences.
// Phase 2 applies random transactions and compares every cycle against a
// behavioural model. In the model, a lane takes its synchronised value once the
// last DEBOUNCE_CYCLES samples all agree on it. A fault latches once one lane
// has been the odd one out for MISMATCH_LIMIT consecutive edges.
// -----------------------------------------------------------------------------
module tb_tmr_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LIM  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw_a = 1'b0, raw_b = 1'b0, raw_c = 1'b0;
    logic       clear_fault = 1'b0;
    logic       a, b, c, agree, mismatch;
    logic [1:0] fault_lane;
`ifdef TMR_FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tmr_input_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .MISMATCH_LIMIT (LIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_a      (raw_a),
        .raw_b      (raw_b),
        .raw_c      (raw_c),
        .clear_fault(clear_fault),
        .a          (a),
        .b          (b),
        .c          (c),
        .agree      (agree),
        .mismatch   (mismatch),
`ifdef TMR_FAULT_COUNT_EN
        .fault_lane (fault_lane),
        .fault_count(fault_count)
`else
        .fault_lane (fault_lane)
`endif
    );

    // ---------------- behavioural reference model ----------------
    bit m_sync [3][SYNC];
    bit m_hist [3][DEB];
    bit m_out  [3];
    bit m_fault;
    int m_lane;
    int m_streak;
    int m_streak_lane;
    int m_fcount;

    // Odd lane out (1=A, 2=B, 3=C), or 0 when all agree.
    function automatic int odd_lane(bit x, bit y, bit z);
        if (x == y && y == z) return 0;
        if (x == y)           return 3;
        if (x == z)           return 2;
        return 1;
    endfunction

    always @(posedge clk) begin : model
        int  mn;
        bit  s;
        bit  all_same;
        bit  rv [3];
        if (rst) begin
            for (int l = 0; l < 3; l++) begin
                for (int k = 0; k < SYNC; k++) m_sync[l][k] = 1'b0;
                for (int k = 0; k < DEB; k++)  m_hist[l][k] = 1'b0;
                m_out[l] = 1'b0;
            end
            m_fault = 1'b0; m_lane = 0; m_streak = 0; m_streak_lane = 0; m_fcount = 0;
        end else begin
            // Monitor sees the lane values held before this edge.
            mn = odd_lane(m_out[0], m_out[1], m_out[2]);
            if (m_fault) begin
                if (clear_fault) begin
                    m_fault = 1'b0; m_lane = 0; m_streak = 0;
                end
            end else if (mn == 0) begin
                m_streak = 0;
            end else begin
                if (m_streak > 0 && mn == m_streak_lane) m_streak++;
                else begin
                    m_streak = 1; m_streak_lane = mn;
                end
                if (m_streak >= LIM) begin
                    m_fault = 1'b1; m_lane = mn;
                    if (m_fcount < 255) m_fcount++;
                end
            end
            rv[0] = raw_a; rv[1] = raw_b; rv[2] = raw_c;
            for (int l = 0; l < 3; l++) begin
                s = m_sync[l][SYNC-1];
                for (int k = SYNC - 1; k > 0; k--) m_sync[l][k] = m_sync[l][k-1];
                m_sync[l][0] = rv[l];
                for (int k = DEB - 1; k > 0; k--) m_hist[l][k] = m_hist[l][k-1];
                m_hist[l][0] = s;
                all_same = 1'b1;
                for (int k = 0; k < DEB; k++) if (m_hist[l][k] != s) all_same = 1'b0;
                if (all_same && s != m_out[l]) m_out[l] = s;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got cba/agree/mis/lane=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [6:0] dut_vec();
        return {c, b, a, agree, mismatch, fault_lane};
    endfunction

    typedef struct {
        bit       rst;
        bit [2:0] raw;       // {c,b,a}
        bit       clr;
        int       cycles;
        bit [2:0] exp_cba;
        bit       exp_agree;
        bit       exp_mis;
        bit [1:0] exp_lane;
    } vec_t;

    vec_t vecs [31];
    int   nvec = 0;

    task automatic add(input bit r, input bit [2:0] raw, input bit clr, input int cyc,
                       input bit [2:0] cba, input bit ag, input bit mis, input bit [1:0] ln);
        vecs[nvec].rst = r;   vecs[nvec].raw = raw;  vecs[nvec].clr = clr;
        vecs[nvec].cycles = cyc; vecs[nvec].exp_cba = cba; vecs[nvec].exp_agree = ag;
        vecs[nvec].exp_mis = mis; vecs[nvec].exp_lane = ln;
        nvec++;
    endtask

    initial begin
        bit [2:0] cur_raw;
        bit [2:0] pat;
        int       hold;
        bit       clr_r, rst_r;
        int       sel;
        logic [6:0] exp_v;

        // rst  raw   clr cyc  cba   ag mis lane
        add(1, 3'b000, 0, 1,  3'b000, 1, 0, 0);  // reset state
        add(0, 3'b000, 0, 3,  3'b000, 1, 0, 0);
        add(0, 3'b111, 0, 5,  3'b000, 1, 0, 0);  // one edge short of latency
        add(0, 3'b111, 0, 1,  3'b111, 1, 0, 0);  // all rise together on edge 6
        add(0, 3'b111, 0, 2,  3'b111, 1, 0, 0);
        add(0, 3'b000, 0, 6,  3'b000, 1, 0, 0);
        add(0, 3'b010, 0, 3,  3'b000, 1, 0, 0);  // 3-cycle glitch on b
        add(0, 3'b000, 0, 8,  3'b000, 1, 0, 0);  // glitch filtered
        add(0, 3'b010, 0, 4,  3'b000, 1, 0, 0);  // 4-cycle pulse on b
        add(0, 3'b000, 0, 2,  3'b010, 0, 0, 0);  // b set 4 edges after sync
        add(0, 3'b000, 0, 6,  3'b000, 1, 0, 0);  // short disagreement, no fault
        add(0, 3'b100, 0, 6,  3'b100, 0, 0, 0);  // c rises
        add(0, 3'b100, 0, 7,  3'b100, 0, 0, 0);  // 7 edges after c: no fault yet
        add(0, 3'b100, 0, 1,  3'b100, 0, 1, 3);  // 8 edges after c: fault on C
        add(0, 3'b000, 0, 10, 3'b000, 1, 1, 3);  // sticky after lanes agree
        add(0, 3'b000, 1, 1,  3'b000, 1, 0, 0);  // clear
        add(0, 3'b001, 0, 14, 3'b001, 0, 1, 1);  // fault on A
        add(0, 3'b001, 0, 1,  3'b001, 0, 1, 1);
        add(0, 3'b001, 1, 1,  3'b001, 0, 0, 0);  // clear wins over disagreement
        add(0, 3'b001, 0, 7,  3'b001, 0, 0, 0);
        add(0, 3'b001, 0, 1,  3'b001, 0, 1, 1);  // refault 8 edges after re-entry
        add(1, 3'b001, 0, 1,  3'b000, 1, 0, 0);  // reset in FAULT
        add(0, 3'b000, 0, 10, 3'b000, 1, 0, 0);  // no fault while raws equal
        add(0, 3'b001, 0, 6,  3'b001, 0, 0, 0);  // A minority
        add(0, 3'b101, 0, 6,  3'b101, 0, 0, 0);  // now B minority
        add(0, 3'b101, 0, 7,  3'b101, 0, 0, 0);  // count restarted on lane change
        add(0, 3'b101, 0, 1,  3'b101, 0, 1, 2);  // fault on B
        add(1, 3'b101, 0, 1,  3'b000, 1, 0, 0);
        add(0, 3'b111, 0, 3,  3'b000, 1, 0, 0);  // mid-debounce
        add(1, 3'b111, 0, 1,  3'b000, 1, 0, 0);  // reset mid-debounce
        add(0, 3'b000, 0, 8,  3'b000, 1, 0, 0);

        for (int i = 0; i < nvec; i++) begin
            rst = vecs[i].rst;
            {raw_c, raw_b, raw_a} = vecs[i].raw;
            clear_fault = vecs[i].clr;
            for (int k = 0; k < vecs[i].cycles; k++) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d", i), dut_vec(),
                  {vecs[i].exp_cba, vecs[i].exp_agree, vecs[i].exp_mis, vecs[i].exp_lane});
            $display("[TB] vec %0d rst=%0d raw=%b clr=%0d cyc=%0d -> cba=%b agree=%0d mis=%0d lane=%0d",
                     i, vecs[i].rst, vecs[i].raw, vecs[i].clr, vecs[i].cycles,
                     {c, b, a}, agree, mismatch, fault_lane);
        end
        clear_fault = 1'b0;
        rst = 1'b0;

        // ---------------- randomized phase ----------------
        cur_raw = 3'b000;
        for (int t = 0; t < 250; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                pat = cur_raw;
                pat[$urandom_range(0, 2)] ^= 1'b1;
            end else if (sel < 6) begin
                pat = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
            end else begin
                pat = 3'($urandom_range(0, 7));
            end
            cur_raw = pat;
            hold  = $urandom_range(1, 20);
            clr_r = ($urandom_range(0, 5) == 0);
            rst_r = ($urandom_range(0, 40) == 0);
            for (int k = 0; k < hold; k++) begin
                rst = (k == 0) ? rst_r : 1'b0;
                clear_fault = (k == 0) ? clr_r : 1'b0;
                {raw_c, raw_b, raw_a} = pat;
                @(posedge clk);
                #1;
                exp_v = {m_out[2], m_out[1], m_out[0],
                         (m_out[0] == m_out[1]) && (m_out[1] == m_out[2]),
                         m_fault, m_lane[1:0]};
                check($sformatf("rnd%0d.%0d", t, k), dut_vec(), exp_v);
`ifdef TMR_FAULT_COUNT_EN
                check($sformatf("rnd_fcount%0d.%0d", t, k), {c, b, a, agree, mismatch, fault_lane} ^ 7'(fault_count),
                      exp_v ^ 7'(m_fcount));
`endif
            end
            $display("[TB] rnd %0d raw=%b hold=%0d clr=%0d rst=%0d -> cba=%b agree=%0d mis=%0d lane=%0d",
                     t, pat, hold, clr_r, rst_r, {c, b, a}, agree, mismatch, fault_lane);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
